mem_lsu: RTL
============

// Module: mem_lsu
// PURPOSE
//  MEM-stage load/store responder for the EX/MEM register; owns the data-memory bus (req/gnt/rvalid).
//  For each memory op it issues one aligned 32-bit bus access, formats load data and stalls the pipe via fc.
//  Non-memory ops pass straight through to WB with no added latency.
// PARAMETERS
//  ADDR_W  32  byte-address width of exmem_op_c_i and dmem_addr_o
// PORTS
//  clk                   in   1       single clock
//  rst                   in   1       reset: synchronous, active-high
//  exmem_op_c_i          in   ADDR_W  ALU result / effective byte address
//  exmem_wdata_i         in   32      store data (rs2)
//  exmem_reg_waddr_i     in   5       destination register
//  exmem_reg_we_i        in   1       register write enable
//  exmem_mtype_i         in   1       1 = memory op
//  exmem_mem_rw_i        in   1       0 = load, 1 = store
//  exmem_mem_width_i     in   2       00 byte, 01 half, 10 word, 11 illegal
//  exmem_mem_unsigned_i  in   1       1 = zero-extend load
//  dmem_req_o            out  1       bus request, held until grant
//  dmem_we_o             out  1       1 = write
//  dmem_addr_o           out  ADDR_W  word-aligned address {a[ADDR_W-1:2],2'b00}
//  dmem_be_o             out  4       byte enables
//  dmem_wdata_o          out  32      lane-replicated store data
//  dmem_gnt_i            in   1       request accepted
//  dmem_rvalid_i         in   1       response / store ack (>=1 cycle after gnt)
//  dmem_rdata_i          in   32      read data, valid with rvalid
//  mem_reg_wdata_o       out  32      writeback data
//  mem_reg_waddr_o       out  5       writeback register
//  mem_reg_we_o          out  1       writeback enable
//  lsu_stall_o           out  1       to fc: hold EX/MEM and upstream
//  lsu_misalign_o        out  1       to fc: misaligned/illegal access
// BEHAVIOUR
//  FSM IDLE->REQ->WAIT->DONE->IDLE; reset forces IDLE, clears all capture regs to 0.
//  IDLE: mtype & aligned -> capture addr/be/wdata/we/width/unsigned into regs, go REQ; else stay IDLE.
//  REQ: dmem_req_o=1 from captured regs; gnt -> WAIT. Captured values are stable until gnt.
//  WAIT: rvalid -> capture formatted load data into ldata_q, go DONE. rvalid outside WAIT is ignored.
//  DONE: one cycle, go IDLE unconditionally.
//  dmem_req_o=0 in IDLE/WAIT/DONE; dmem_we/addr/be/wdata are 0 outside REQ.
//  lsu_stall_o = exmem_mtype_i & ~misalign & (state!=DONE).
//  Best case: mem op in cycle N, gnt in N+1, rvalid in N+2, DONE in N+3, EX/MEM advances at end of N+3.
//  Writeback: waddr_o = exmem_reg_waddr_i.
//   we_o = exmem_reg_we_i & ~misalign & (~mtype | state==DONE).
//   wdata_o = ldata_q in DONE, else exmem_op_c_i.
//  Misalign (IDLE only): half & a[0], word & a[1:0]!=0, or width 11.
//   Asserts lsu_misalign_o for that cycle, no bus request, no stall, we_o=0; fc handles flush.
//  Stores: be byte = 4'b0001<<a[1:0], half = 4'b0011<<{a[1],1'b0}, word = 4'hF.
//   wdata byte = {4{d[7:0]}}, half = {2{d[15:0]}}, word = d.
//  Loads: byte = lane a[1:0], half = lane a[1], word = full word; sign-extend unless unsigned.
//  An access in flight is never abandoned; fc must not flush EX/MEM while lsu_stall_o=1.
//  Reset mid-access drops req immediately; the memory is reset by the same rst.
//  gnt and rvalid in the same cycle while in REQ: rvalid is ignored (protocol violation).
// STRUCTURE
//  core_pkg holds MEM_W_BYTE/HALF/WORD encodings and the LSU state encoding (IDLE, REQ, WAIT, DONE).
//  Sub-module lsu_fmt (combinational) does be/wdata generation and load lane extract/extend.
//  mem_lsu holds the FSM, capture regs and WB mux.
// TESTING
//  ALU op (mtype=0, op_c=0x1234, we=1) -> wdata_o=0x1234 same cycle, stall=0, req never asserted.
//  lw @0x100, gnt same cycle as req, rvalid next with 0xDEADBEEF -> stall 3 cycles, DONE wdata_o=0xDEADBEEF.
//  lb @0x103, rdata 0x80xxxxxx -> 0xFFFFFF80; lbu -> 0x00000080; lh @0x102 rdata 0x8001xxxx -> 0xFFFF8001.
//  sh @0x202 data 0x0000ABCD -> addr 0x200, be 4'b1100, wdata 0xABCDABCD, we=1, mem_reg_we_o=0.
//  gnt withheld 5 cycles -> req and payload held constant, stall high throughout.
//  lw @0x101 -> misalign=1, req=0, stall=0, we_o=0; rst during WAIT -> IDLE next cycle, req=0.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared encodings for the MEM-stage load/store unit
package core_pkg;

  localparam logic [1:0] MEM_W_BYTE = 2'b00;
  localparam logic [1:0] MEM_W_HALF = 2'b01;
  localparam logic [1:0] MEM_W_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_fmt.sv
// rtl/lsu_fmt.sv - store byte-enable/lane replication and load lane extract/extend
module lsu_fmt
  import core_pkg::*;
(
  input  logic [1:0]  width_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    ldata_o = 32'h0;
    case (width_i)
      MEM_W_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{sdata_i[7:0]}};
        ldata_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
      end
      MEM_W_HALF: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{sdata_i[15:0]}};
        ldata_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
      end
      MEM_W_WORD: begin
        be_o    = 4'b1111;
        wdata_o = sdata_i;
        ldata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store responder: bus FSM, capture regs, WB mux
module mem_lsu
  import core_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] exmem_op_c_i,
  input  logic [31:0]       exmem_wdata_i,
  input  logic [4:0]        exmem_reg_waddr_i,
  input  logic              exmem_reg_we_i,
  input  logic              exmem_mtype_i,
  input  logic              exmem_mem_rw_i,
  input  logic [1:0]        exmem_mem_width_i,
  input  logic              exmem_mem_unsigned_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic [31:0]       mem_reg_wdata_o,
  output logic [4:0]        mem_reg_waddr_o,
  output logic              mem_reg_we_o,
  output logic              lsu_stall_o,
  output logic              lsu_misalign_o
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [1:0]        width_q;
  logic [1:0]        alo_q;
  logic              uns_q;
  logic [31:0]       ldata_q;

  logic        in_idle, in_req, in_wait, in_done;
  logic        misalign, start;
  logic [1:0]  fmt_width, fmt_alo;
  logic        fmt_uns;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_ldata;

  assign in_idle = (state_q == LSU_IDLE);
  assign in_req  = (state_q == LSU_REQ);
  assign in_wait = (state_q == LSU_WAIT);
  assign in_done = (state_q == LSU_DONE);

  assign misalign = in_idle & exmem_mtype_i &
                    (((exmem_mem_width_i == MEM_W_HALF) & exmem_op_c_i[0]) |
                     ((exmem_mem_width_i == MEM_W_WORD) & (exmem_op_c_i[1:0] != 2'b00)) |
                     (exmem_mem_width_i == 2'b11));
  assign start    = in_idle & exmem_mtype_i & ~misalign;

  // The formatter sees live EX/MEM fields when capturing, captured fields when formatting the response.
  assign fmt_width = in_idle ? exmem_mem_width_i    : width_q;
  assign fmt_alo   = in_idle ? exmem_op_c_i[1:0]    : alo_q;
  assign fmt_uns   = in_idle ? exmem_mem_unsigned_i : uns_q;

  lsu_fmt u_fmt (
    .width_i    (fmt_width),
    .addr_lo_i  (fmt_alo),
    .unsigned_i (fmt_uns),
    .sdata_i    (exmem_wdata_i),
    .rdata_i    (dmem_rdata_i),
    .be_o       (fmt_be),
    .wdata_o    (fmt_wdata),
    .ldata_o    (fmt_ldata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (start)         state_d = LSU_REQ;
      LSU_REQ:  if (dmem_gnt_i)    state_d = LSU_WAIT;
      LSU_WAIT: if (dmem_rvalid_i) state_d = LSU_DONE;
      LSU_DONE:                    state_d = LSU_IDLE;
      default:                     state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      width_q <= 2'b00;
      alo_q   <= 2'b00;
      uns_q   <= 1'b0;
      ldata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q  <= {exmem_op_c_i[ADDR_W-1:2], 2'b00};
        be_q    <= fmt_be;
        wdata_q <= fmt_wdata;
        we_q    <= exmem_mem_rw_i;
        width_q <= exmem_mem_width_i;
        alo_q   <= exmem_op_c_i[1:0];
        uns_q   <= exmem_mem_unsigned_i;
      end
      if (in_wait && dmem_rvalid_i) begin
        ldata_q <= fmt_ldata;
      end
    end
  end

  // Request is masked by rst so the bus sees it drop in the reset cycle itself.
  assign dmem_req_o   = in_req & ~rst;
  assign dmem_we_o    = in_req & we_q;
  assign dmem_addr_o  = in_req ? addr_q  : '0;
  assign dmem_be_o    = in_req ? be_q    : 4'b0000;
  assign dmem_wdata_o = in_req ? wdata_q : 32'h0;

  assign lsu_stall_o     = exmem_mtype_i & ~misalign & ~in_done;
  assign lsu_misalign_o  = misalign;
  assign mem_reg_waddr_o = exmem_reg_waddr_i;
  assign mem_reg_we_o    = exmem_reg_we_i & ~misalign & (~exmem_mtype_i | in_done);
  assign mem_reg_wdata_o = in_done ? ldata_q : 32'(exmem_op_c_i);

endmodule
